display_page_sched: RTL

- Scheduler that drives the 2-bit page select of the 8-digit hex display driver.
- Chooses which 32-bit page is shown: register page 0, page 1, page 2, or blank.
- Sources of page changes: debounced board buttons (manual step, auto-rotate toggle) and a single priority alert requester (e.g. trap/halt logic forcing a page).
- Sits between board I/O / CPU status and the display driver's disp_ctrl input.

---
 rtl/display_page_sched.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/display_page_sched.sv
// display_page_sched: chooses which 32-bit page the 8-digit hex display shows.
// The selected page goes out on disp_ctrl: 00/01/10 select page 0..2, 11 blanks the display.
// Page changes come from two debounced board buttons (step, auto-rotate toggle)
// and from one priority alert requester that can take over the display.
// Optional feature: define DISP_SCHED_BLANK_EN to blank the display for
// BLANK_CYCLES cycles on every scheduled page change. The blank counter only
// exists when the macro is defined.

// Per-button conditioning: 2-flop synchronizer, stability debounce and a
// registered one-cycle pulse on the debounced press (release is silent).
module display_page_sched_btn #(
    parameter int DB_MAX = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int DB_W = $clog2(DB_MAX);
    localparam logic [DB_W-1:0] DB_TERM = DB_W'(DB_MAX - 1);
    localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0] DB_ZERO = DB_W'(0);

    logic            sync1_r;
    logic            sync2_r;
    logic            deb_r;
    logic            deb_d_r;
    logic            pulse_r;
    logic [DB_W-1:0] cnt_r;

    // Synchronize, debounce and edge-detect the raw button level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            deb_r   <= 1'b0;
            deb_d_r <= 1'b0;
            pulse_r <= 1'b0;
            cnt_r   <= DB_ZERO;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r == deb_r) begin
                cnt_r <= DB_ZERO;
            end else if (cnt_r == DB_TERM) begin
                deb_r <= sync2_r;
                cnt_r <= DB_ZERO;
            end else begin
                cnt_r <= cnt_r + DB_ONE;
            end
            deb_d_r <= deb_r;
            pulse_r <= deb_r & ~deb_d_r;
        end
    end

    assign pulse = pulse_r;
endmodule

module display_page_sched #(
    parameter int DB_MAX       = 50000,
    parameter int DWELL_MAX    = 50000000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_mode,
    input  logic       alert_req,
    input  logic [1:0] alert_page,
    output logic       alert_ack,
    output logic [1:0] disp_ctrl,
    output logic [1:0] page_idx,
    output logic       auto_mode
);
    localparam int DWELL_W = $clog2(DWELL_MAX);
    localparam logic [DWELL_W-1:0] DWELL_TERM = DWELL_W'(DWELL_MAX - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ZERO = DWELL_W'(0);

    // Out-of-range configuration is rejected at elaboration.
    if ((DB_MAX < 2) || (DWELL_MAX < 2) || (BLANK_CYCLES < 1)) begin : g_param_check
        $error("display_page_sched: DB_MAX/DWELL_MAX must be >= 2, BLANK_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_MANUAL = 2'd0,
        ST_AUTO   = 2'd1,
        ST_ALERT  = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_nx_s;
    logic                 saved_auto_r;
    logic                 saved_nx_s;
    logic [1:0]           page_idx_r;
    logic [1:0]           page_nx_s;
    logic [DWELL_W-1:0]   dwell_r;
    logic [DWELL_W-1:0]   dwell_nx_s;
    logic [1:0]           disp_ctrl_r;
    logic [1:0]           disp_nx_s;
    logic                 alert_ack_r;
    logic                 ack_nx_s;
    logic                 auto_mode_r;
    logic                 auto_nx_s;
    logic                 adv_s;
    logic                 next_pulse_s;
    logic                 mode_pulse_s;
    logic                 blank_busy_s;
    logic                 blank_show_s;

    // Page rotation order 0 -> 1 -> 2 -> 0; the value 3 is never produced.
    function automatic logic [1:0] next_page(input logic [1:0] p);
        if (p == 2'd2) begin
            return 2'd0;
        end else begin
            return p + 2'd1;
        end
    endfunction

    display_page_sched_btn #(.DB_MAX(DB_MAX)) u_btn_next (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_next),
        .pulse (next_pulse_s)
    );

    display_page_sched_btn #(.DB_MAX(DB_MAX)) u_btn_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_mode),
        .pulse (mode_pulse_s)
    );

    // State register plus the registered page, dwell and output values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_MANUAL;
            saved_auto_r <= 1'b0;
            page_idx_r   <= 2'd0;
            dwell_r      <= DWELL_ZERO;
            disp_ctrl_r  <= 2'b00;
            alert_ack_r  <= 1'b0;
            auto_mode_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            saved_auto_r <= saved_nx_s;
            page_idx_r   <= page_nx_s;
            dwell_r      <= dwell_nx_s;
            disp_ctrl_r  <= disp_nx_s;
            alert_ack_r  <= ack_nx_s;
            auto_mode_r  <= auto_nx_s;
        end
    end

    // Next state: an alert pre-empts everything, a mode pulse toggles MANUAL/AUTO.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_MANUAL: begin
                if (alert_req) begin
                    state_nx_s = ST_ALERT;
                end else if (mode_pulse_s) begin
                    state_nx_s = ST_AUTO;
                end else begin
                    state_nx_s = ST_MANUAL;
                end
            end
            ST_AUTO: begin
                if (alert_req) begin
                    state_nx_s = ST_ALERT;
                end else if (mode_pulse_s) begin
                    state_nx_s = ST_MANUAL;
                end else begin
                    state_nx_s = ST_AUTO;
                end
            end
            ST_ALERT: begin
                if (!alert_req) begin
                    state_nx_s = saved_auto_r ? ST_AUTO : ST_MANUAL;
                end else begin
                    state_nx_s = ST_ALERT;
                end
            end
            default: begin
                state_nx_s = ST_MANUAL;
            end
        endcase
    end

    // Page advance, dwell timing and mode save; alert entry swallows button pulses.
    always_comb begin
        adv_s      = 1'b0;
        dwell_nx_s = dwell_r;
        saved_nx_s = saved_auto_r;
        case (state_r)
            ST_MANUAL: begin
                if (alert_req) begin
                    saved_nx_s = 1'b0;
                end else begin
                    adv_s = next_pulse_s;
                    if (mode_pulse_s) begin
                        dwell_nx_s = DWELL_ZERO;
                    end else begin
                        dwell_nx_s = dwell_r;
                    end
                end
            end
            ST_AUTO: begin
                if (alert_req) begin
                    saved_nx_s = 1'b1;
                end else if (next_pulse_s) begin
                    adv_s      = 1'b1;
                    dwell_nx_s = DWELL_ZERO;
                end else if (blank_busy_s) begin
                    dwell_nx_s = dwell_r;
                end else if (dwell_r == DWELL_TERM) begin
                    adv_s      = 1'b1;
                    dwell_nx_s = DWELL_ZERO;
                end else begin
                    dwell_nx_s = dwell_r + DWELL_ONE;
                end
            end
            ST_ALERT: begin
                dwell_nx_s = dwell_r;
            end
            default: begin
                adv_s = 1'b0;
            end
        endcase
        if (adv_s) begin
            page_nx_s = next_page(page_idx_r);
        end else begin
            page_nx_s = page_idx_r;
        end
    end

`ifdef DISP_SCHED_BLANK_EN
    localparam int BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_TERM = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
    localparam logic [BLANK_W-1:0] BLANK_ZERO = BLANK_W'(0);

    logic               blank_act_r;
    logic               blank_act_nx_s;
    logic [BLANK_W-1:0] blank_cnt_r;
    logic [BLANK_W-1:0] blank_cnt_nx_s;

    // Blank interval register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blank_act_r <= 1'b0;
            blank_cnt_r <= BLANK_ZERO;
        end else begin
            blank_act_r <= blank_act_nx_s;
            blank_cnt_r <= blank_cnt_nx_s;
        end
    end

    // Any advance (re)starts the blank; an alert aborts it at once.
    always_comb begin
        blank_act_nx_s = blank_act_r;
        blank_cnt_nx_s = blank_cnt_r;
        if (state_nx_s == ST_ALERT) begin
            blank_act_nx_s = 1'b0;
            blank_cnt_nx_s = BLANK_ZERO;
        end else if (adv_s) begin
            blank_act_nx_s = 1'b1;
            blank_cnt_nx_s = BLANK_ZERO;
        end else if (blank_act_r) begin
            if (blank_cnt_r == BLANK_TERM) begin
                blank_act_nx_s = 1'b0;
                blank_cnt_nx_s = BLANK_ZERO;
            end else begin
                blank_act_nx_s = 1'b1;
                blank_cnt_nx_s = blank_cnt_r + BLANK_ONE;
            end
        end else begin
            blank_act_nx_s = 1'b0;
            blank_cnt_nx_s = BLANK_ZERO;
        end
    end

    assign blank_busy_s = blank_act_r;
    assign blank_show_s = blank_act_nx_s;
`else
    assign blank_busy_s = 1'b0;
    assign blank_show_s = 1'b0;
`endif

    // Output values for the next cycle: alert page, blank, or scheduled page.
    always_comb begin
        disp_nx_s = page_nx_s;
        if (state_nx_s == ST_ALERT) begin
            disp_nx_s = alert_page;
        end else if (blank_show_s) begin
            disp_nx_s = 2'b11;
        end else begin
            disp_nx_s = page_nx_s;
        end
        ack_nx_s  = (state_nx_s == ST_ALERT);
        auto_nx_s = (state_nx_s == ST_AUTO) | ((state_nx_s == ST_ALERT) & saved_nx_s);
    end

    assign alert_ack = alert_ack_r;
    assign disp_ctrl = disp_ctrl_r;
    assign page_idx  = page_idx_r;
    assign auto_mode = auto_mode_r;
endmodule
